// File: rtl/eth_avalon_rxdma_pkg.sv
// Shared types and FIFO word layout for the RX-DMA write master.
// The frame counter block is built only when ETH_RXDMA_FRAME_CNT_EN is defined.
package eth_avalon_rxdma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2,
        DONE  = 2'd3
    } rxdma_state_e;

    // FIFO word: [31:0] data, [33:32] last-word byte count - 1, [34] EOF, [35] frame error.
    localparam int DATA_MSB = 31;
    localparam int CNT_LSB  = 32;
    localparam int EOF_BIT  = 34;
    localparam int ERR_BIT  = 35;

    // Little-endian byte enables; only an EOF word can be partially filled.
    function automatic logic [3:0] be_lookup(input logic eof, input logic [1:0] cnt);
        logic [3:0] be;
        if (!eof) begin
            be = 4'b1111;
        end else begin
            unique case (cnt)
                2'd0:    be = 4'b0001;
                2'd1:    be = 4'b0011;
                2'd2:    be = 4'b0111;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/eth_rxdma_len_chk.sv
// Decodes the FIFO head into a byte count and byte enables, and flags a word
// that would push the frame past the buffer size.
module eth_rxdma_len_chk
    import eth_avalon_rxdma_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 eof_i,
    input  logic [1:0]           cnt_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic [LEN_WIDTH-1:0] maxlen_i,
    output logic [2:0]           word_bytes_o,
    output logic [3:0]           byteenable_o,
    output logic                 overrun_o
);

    logic [LEN_WIDTH:0] sum;

    assign word_bytes_o = eof_i ? ({1'b0, cnt_i} + 3'd1) : 3'd4;
    assign byteenable_o = be_lookup(eof_i, cnt_i);

    // One extra bit keeps len + word_bytes from wrapping near the top of the range.
    assign sum       = {1'b0, len_i} + {{(LEN_WIDTH-2){1'b0}}, word_bytes_o};
    assign overrun_o = sum > {1'b0, maxlen_i};

endmodule

// File: rtl/eth_avalon_rxdma_wr.sv
// RX-DMA write master: drains frame words from the show-ahead RX FIFO into an
// Avalon-MM buffer, one descriptor per frame, one status strobe per frame.
// Optional frame/error counters are built when ETH_RXDMA_FRAME_CNT_EN is defined.
module eth_avalon_rxdma_wr
    import eth_avalon_rxdma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [FIFO_WIDTH-1:0] fifo_q,
    input  logic                  fifo_rdempty,
    output logic                  fifo_rdreq,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH-1:0] desc_addr,
    input  logic [LEN_WIDTH-1:0]  desc_maxlen,
    output logic [ADDR_WIDTH-1:0] av_address,
    output logic                  av_write,
    output logic [31:0]           av_writedata,
    output logic [3:0]            av_byteenable,
    input  logic                  av_waitrequest,
    output logic                  stat_valid,
    output logic [LEN_WIDTH-1:0]  stat_len,
    output logic                  stat_err,
    output logic                  stat_overrun
`ifdef ETH_RXDMA_FRAME_CNT_EN
    ,
    output logic [15:0]           cnt_frames,
    output logic [15:0]           cnt_errors
`endif
);

    rxdma_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  maxlen_q, maxlen_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic                  ready_q;
    logic [LEN_WIDTH-1:0]  stat_len_q;
    logic                  stat_err_q, stat_ovr_q;

    logic                  head_valid;
    logic                  head_eof;
    logic [2:0]            word_bytes;
    logic                  overrun;
    logic                  unused_addr_lsbs;

    assign head_valid       = !fifo_rdempty;
    assign head_eof         = fifo_q[EOF_BIT];
    assign unused_addr_lsbs = ^desc_addr[1:0];

    eth_rxdma_len_chk #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_len_chk (
        .eof_i        (head_eof),
        .cnt_i        (fifo_q[CNT_LSB+1:CNT_LSB]),
        .len_i        (len_q),
        .maxlen_i     (maxlen_q),
        .word_bytes_o (word_bytes),
        .byteenable_o (av_byteenable),
        .overrun_o    (overrun)
    );

    // Address and data come straight from registers and the un-popped head,
    // so they hold steady for the whole of a waitrequest stall.
    assign av_address   = addr_q;
    assign av_writedata = fifo_q[DATA_MSB:0];
    assign desc_ready   = ready_q && (state_q == IDLE);
    assign stat_valid   = (state_q == DONE);
    assign stat_len     = stat_len_q;
    assign stat_err     = stat_err_q;
    assign stat_overrun = stat_ovr_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        maxlen_d   = maxlen_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        av_write   = 1'b0;
        fifo_rdreq = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (desc_valid && ready_q) begin
                    addr_d   = {desc_addr[ADDR_WIDTH-1:2], 2'b00};
                    maxlen_d = desc_maxlen;
                    len_d    = '0;
                    err_d    = 1'b0;
                    ovr_d    = 1'b0;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (head_valid) begin
                    if (overrun) begin
                        ovr_d   = 1'b1;
                        state_d = DROP;
                    end else begin
                        av_write = 1'b1;
                        if (!av_waitrequest) begin
                            fifo_rdreq = 1'b1;
                            addr_d     = addr_q + ADDR_WIDTH'(4);
                            len_d      = len_q + LEN_WIDTH'(word_bytes);
                            if (head_eof) begin
                                err_d   = fifo_q[ERR_BIT];
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (head_valid) begin
                    fifo_rdreq = 1'b1;
                    if (head_eof) begin
                        err_d   = fifo_q[ERR_BIT];
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            maxlen_q   <= '0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ready_q    <= 1'b0;
            stat_len_q <= '0;
            stat_err_q <= 1'b0;
            stat_ovr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            maxlen_q <= maxlen_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            ready_q  <= 1'b1;
            // Status is captured on entry to DONE and held until the next frame ends.
            if (state_d == DONE) begin
                stat_len_q <= len_d;
                stat_err_q <= err_d;
                stat_ovr_q <= ovr_d;
            end
        end
    end

`ifdef ETH_RXDMA_FRAME_CNT_EN
    logic [15:0] cnt_frames_q, cnt_errors_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_frames_q <= '0;
            cnt_errors_q <= '0;
        end else if (state_q == DONE) begin
            cnt_frames_q <= cnt_frames_q + 16'd1;
            if (err_q || ovr_q) begin
                cnt_errors_q <= cnt_errors_q + 16'd1;
            end
        end
    end

    assign cnt_frames = cnt_frames_q;
    assign cnt_errors = cnt_errors_q;
`endif

endmodule

// File: tb/tb_eth_avalon_rxdma_wr.sv
// Directed bench for eth_avalon_rxdma_wr: a queue models the show-ahead FIFO,
// a log records every accepted Avalon write, expectations are hand-computed.
module tb_eth_avalon_rxdma_wr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [35:0] fifo_q;
    logic        fifo_rdempty;
    logic        fifo_rdreq;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_addr;
    logic [15:0] desc_maxlen;
    logic [31:0] av_address;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_waitrequest;
    logic        stat_valid;
    logic [15:0] stat_len;
    logic        stat_err;
    logic        stat_overrun;
`ifdef ETH_RXDMA_FRAME_CNT_EN
    logic [15:0] cnt_frames;
    logic [15:0] cnt_errors;
`endif

    int total = 0;
    int bad   = 0;

    logic [35:0] fq[$];
    logic [67:0] wlog[$];
    logic [67:0] exp_w[$];
    logic        gap;

    always #5 clk = ~clk;

    eth_avalon_rxdma_wr dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fifo_q         (fifo_q),
        .fifo_rdempty   (fifo_rdempty),
        .fifo_rdreq     (fifo_rdreq),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_addr      (desc_addr),
        .desc_maxlen    (desc_maxlen),
        .av_address     (av_address),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_byteenable  (av_byteenable),
        .av_waitrequest (av_waitrequest),
        .stat_valid     (stat_valid),
        .stat_len       (stat_len),
        .stat_err       (stat_err),
        .stat_overrun   (stat_overrun)
`ifdef ETH_RXDMA_FRAME_CNT_EN
        ,
        .cnt_frames     (cnt_frames),
        .cnt_errors     (cnt_errors)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void refresh();
        fifo_q       = (fq.size() > 0) ? fq[0] : 36'd0;
        fifo_rdempty = (fq.size() == 0) || gap;
    endfunction

    function automatic logic [35:0] fw(input bit err, input bit eof, input logic [1:0] cnt,
                                       input logic [31:0] d);
        return {err, eof, cnt, d};
    endfunction

    // Writes are logged at the edge they are accepted; pops land just after the edge.
    always @(posedge clk) begin
        if (av_write && !av_waitrequest) begin
            wlog.push_back({av_address, av_writedata, av_byteenable});
        end
        if (fifo_rdreq) begin
            #1;
            if (fq.size() > 0) begin
                void'(fq.pop_front());
            end
            refresh();
        end
    end

    task automatic push3(input logic [31:0] base, input logic [31:0] addr);
        fq.push_back(fw(1'b0, 1'b0, 2'd0, base + 32'd1));
        fq.push_back(fw(1'b0, 1'b0, 2'd0, base + 32'd2));
        fq.push_back(fw(1'b0, 1'b1, 2'd1, base + 32'd3));
        refresh();
        exp_w.push_back({addr,          base + 32'd1, 4'b1111});
        exp_w.push_back({addr + 32'd4,  base + 32'd2, 4'b1111});
        exp_w.push_back({addr + 32'd8,  base + 32'd3, 4'b0011});
    endtask

    // Returns one negedge after acceptance, with the DUT in WRITE.
    task automatic send_desc(input logic [31:0] addr, input logic [15:0] maxlen);
        @(negedge clk);
        desc_valid  = 1'b1;
        desc_addr   = addr;
        desc_maxlen = maxlen;
        @(negedge clk);
        desc_valid  = 1'b0;
    endtask

    task automatic wait_stat(input string tag, input logic [15:0] len, input bit err, input bit ovr);
        int n = 0;
        while (!stat_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_stat_valid"}, 64'(stat_valid), 64'd1);
        check({tag, "_stat_len"}, 64'(stat_len), 64'(len));
        check({tag, "_stat_err"}, 64'(stat_err), 64'(err));
        check({tag, "_stat_ovr"}, 64'(stat_overrun), 64'(ovr));
    endtask

    task automatic check_log(input string tag);
        int n;
        check({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_w.size()));
        n = (wlog.size() < exp_w.size()) ? wlog.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wlog[i][67:36]), 64'(exp_w[i][67:36]));
            check($sformatf("%s_data%0d", tag, i), 64'(wlog[i][35:4]),  64'(exp_w[i][35:4]));
            check($sformatf("%s_be%0d",   tag, i), 64'(wlog[i][3:0]),   64'(exp_w[i][3:0]));
        end
        wlog.delete();
        exp_w.delete();
    endtask

    initial begin
        logic [31:0] s_addr, s_data;
        logic [3:0]  s_be;

        reset_n        = 1'b0;
        desc_valid     = 1'b0;
        desc_addr      = '0;
        desc_maxlen    = '0;
        av_waitrequest = 1'b0;
        gap            = 1'b0;
        refresh();

        // Reset state
        #2;
        check("rst_av_write", 64'(av_write), 64'd0);
        check("rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("rst_stat_valid", 64'(stat_valid), 64'd0);
        check("rst_desc_ready", 64'(desc_ready), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 check("rel_desc_ready_pre", 64'(desc_ready), 64'd0);
        @(negedge clk);
        check("rel_desc_ready_post", 64'(desc_ready), 64'd1);

        // Basic 3-word frame, 10 bytes
        push3(32'hA0A0_0000, 32'h0000_1000);
        send_desc(32'h0000_1000, 16'd1518);
        check("t1_latency_write", 64'(av_write), 64'd1);
        check("t1_latency_addr", 64'(av_address), 64'h1000);
        wait_stat("t1", 16'd10, 1'b0, 1'b0);
        check_log("t1");

        // Three-cycle waitrequest stall on word 2
        push3(32'hB0B0_0000, 32'h0000_1000);
        send_desc(32'h0000_1000, 16'd1518);
        @(negedge clk);
        av_waitrequest = 1'b1;
        #1;
        s_addr = av_address;
        s_data = av_writedata;
        s_be   = av_byteenable;
        check("t2_stall_addr", 64'(s_addr), 64'h1004);
        check("t2_stall_data", 64'(s_data), 64'hB0B0_0002);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_rdreq%0d", i), 64'(fifo_rdreq), 64'd0);
            check($sformatf("t2_write%0d", i), 64'(av_write), 64'd1);
            check($sformatf("t2_hold_addr%0d", i), 64'(av_address), 64'(s_addr));
            check($sformatf("t2_hold_data%0d", i), 64'(av_writedata), 64'(s_data));
            check($sformatf("t2_hold_be%0d", i), 64'(av_byteenable), 64'(s_be));
            @(negedge clk);
        end
        av_waitrequest = 1'b0;
        wait_stat("t2", 16'd10, 1'b0, 1'b0);
        check_log("t2");

        // Overrun at word 2 with maxlen 6
        push3(32'hC0C0_0000, 32'h0000_1000);
        void'(exp_w.pop_back());
        void'(exp_w.pop_back());
        send_desc(32'h0000_1000, 16'd6);
        wait_stat("t3", 16'd4, 1'b0, 1'b1);
        check_log("t3");
        check("t3_fifo_drained", 64'(fq.size()), 64'd0);
        @(negedge clk);
        check("t3_stat_valid_1cyc", 64'(stat_valid), 64'd0);
        check("t3_stat_len_hold", 64'(stat_len), 64'd4);

        // Error flag on a single full EOF word; unaligned descriptor address
        fq.push_back(fw(1'b1, 1'b1, 2'd3, 32'hD0D0_0001));
        refresh();
        exp_w.push_back({32'h0000_2000, 32'hD0D0_0001, 4'b1111});
        send_desc(32'h0000_2002, 16'd1518);
        wait_stat("t4", 16'd4, 1'b1, 1'b0);
        check_log("t4");
`ifdef ETH_RXDMA_FRAME_CNT_EN
        @(negedge clk);
        check("t4_cnt_frames", 64'(cnt_frames), 64'd4);
        check("t4_cnt_errors", 64'(cnt_errors), 64'd2);
`endif

        // maxlen = 0 drops the whole frame
        fq.push_back(fw(1'b0, 1'b0, 2'd0, 32'h1111_0001));
        fq.push_back(fw(1'b0, 1'b1, 2'd2, 32'h1111_0002));
        refresh();
        send_desc(32'h0000_6000, 16'd0);
        wait_stat("t5", 16'd0, 1'b0, 1'b1);
        check_log("t5");
        check("t5_fifo_drained", 64'(fq.size()), 64'd0);

        // FIFO empty for 10 cycles mid-frame; a stray descriptor is ignored
        push3(32'hE0E0_0000, 32'h0000_3000);
        send_desc(32'h0000_3000, 16'd1518);
        @(negedge clk);
        gap = 1'b1;
        refresh();
        for (int i = 0; i < 10; i++) begin
            desc_valid = (i == 4);
            desc_addr  = 32'h0000_9000;
            #1 check($sformatf("t6_gap_write%0d", i), 64'(av_write), 64'd0);
            @(negedge clk);
        end
        desc_valid = 1'b0;
        gap = 1'b0;
        refresh();
        #1;
        check("t6_resume_write", 64'(av_write), 64'd1);
        check("t6_resume_addr", 64'(av_address), 64'h3004);
        wait_stat("t6", 16'd10, 1'b0, 1'b0);
        check_log("t6");
`ifdef ETH_RXDMA_FRAME_CNT_EN
        @(negedge clk);
        check("t6_cnt_frames", 64'(cnt_frames), 64'd6);
        check("t6_cnt_errors", 64'(cnt_errors), 64'd3);
`endif

        // Reset mid-frame, then a clean 1-byte frame
        push3(32'hF0F0_0000, 32'h0000_4000);
        send_desc(32'h0000_4000, 16'd1518);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t7_rst_write", 64'(av_write), 64'd0);
        check("t7_rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("t7_rst_stat_valid", 64'(stat_valid), 64'd0);
        check("t7_rst_stat_len", 64'(stat_len), 64'd0);
        check("t7_rst_stat_err", 64'(stat_err), 64'd0);
        check("t7_rst_stat_ovr", 64'(stat_overrun), 64'd0);
        check("t7_rst_desc_ready", 64'(desc_ready), 64'd0);
`ifdef ETH_RXDMA_FRAME_CNT_EN
        check("t7_rst_cnt_frames", 64'(cnt_frames), 64'd0);
`endif
        fq.delete();
        refresh();
        wlog.delete();
        exp_w.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t7_desc_ready", 64'(desc_ready), 64'd1);
        fq.push_back(fw(1'b0, 1'b1, 2'd0, 32'h5A5A_0001));
        refresh();
        exp_w.push_back({32'h0000_5000, 32'h5A5A_0001, 4'b0001});
        send_desc(32'h0000_5000, 16'd1518);
        wait_stat("t7", 16'd1, 1'b0, 1'b0);
        check_log("t7");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_avalon_rxdma_wr.md
Name: eth_avalon_rxdma_wr

Overview:
- Receive-DMA write master on the Avalon clock domain. It consumes frame words from the read side of the show-ahead dual-clock RX FIFO and writes them to system memory through an Avalon-MM write master.
- It accepts one buffer descriptor per frame and returns a status word when the frame completes, including length, error and overrun.
- It sits directly downstream of the RX FIFO and upstream of the descriptor/status logic.

Parameters:
- ADDR_WIDTH, 32, Avalon byte address width.
- LEN_WIDTH, 16, width of the descriptor max-length and the status length, in bytes.
- FIFO_WIDTH, 36, FIFO word width. Fixed layout: [31:0] data, [33:32] last-word byte count minus 1, [34] EOF, [35] frame error.

Ports:
- clk  in  1  Avalon clock, also the FIFO rdclk.
- reset_n  in  1  asynchronous active-low reset.
- fifo_q  in  FIFO_WIDTH  FIFO head word (show-ahead).
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdreq  out  1  pops the head word.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  block is idle and can accept a descriptor.
- desc_addr  in  ADDR_WIDTH  buffer start address; word aligned, bits [1:0] are ignored.
- desc_maxlen  in  LEN_WIDTH  buffer size in bytes.
- av_address  out  ADDR_WIDTH  write address.
- av_write  out  1  write request.
- av_writedata  out  32  write data.
- av_byteenable  out  4  byte enables.
- av_waitrequest  in  1  slave stall.
- stat_valid  out  1  one-cycle status strobe.
- stat_len  out  LEN_WIDTH  bytes written for the frame.
- stat_err  out  1  frame error flag taken from the EOF word.
- stat_overrun  out  1  frame exceeded desc_maxlen.

Behaviour:
- Reset: asynchronous, active-low.
  - State returns to IDLE.
  - Address register, length accumulator, err flag and ovr flag clear to 0.
  - Outputs while reset is held: av_write=0, fifo_rdreq=0, stat_valid=0, stat_len=0, stat_err=0, stat_overrun=0, desc_ready=0.
  - desc_ready=1 from the first clock edge after deassertion.
- States:
  - IDLE: desc_ready=1. On desc_valid, latch {desc_addr[ADDR_WIDTH-1:2],2'b00}, latch maxlen, clear len/err/ovr, go to WRITE on the next cycle.
  - WRITE, word path: av_write = !fifo_rdempty; av_writedata = fifo_q[31:0]; av_address = address register.
  - WRITE, pop: fifo_rdreq = av_write & !av_waitrequest. On each pop, address += 4 and len += word_bytes. word_bytes = EOF ? fifo_q[33:32]+1 : 4.
  - WRITE, byte enables: av_byteenable = 4'b1111 when EOF is clear. On an EOF word it follows byte count: 0→0001, 1→0011, 2→0111, 3→1111 (little-endian).
  - WRITE, overrun: if len + word_bytes > maxlen while the head is valid, do not assert av_write for that word. Set ovr and go to DROP on the same cycle; the word is not popped.
  - WRITE, EOF: an EOF word that is popped captures err = fifo_q[35] and goes to DONE.
  - DROP: av_write=0; fifo_rdreq = !fifo_rdempty; the dropped words do not count toward len. Popping an EOF word captures err and goes to DONE.
  - DONE: stat_valid=1 for exactly one cycle, with stat_len=len, stat_err=err, stat_overrun=ovr. Next state is IDLE.
- Registers: stat_len/stat_err/stat_overrun hold their values until the next DONE.
- Avalon stability: av_address, av_writedata and av_byteenable are driven from registers and the un-popped FIFO head, so they stay stable while av_waitrequest=1.
- Latency: descriptor acceptance to the first av_write is one cycle, provided the FIFO is non-empty.
- Edge cases:
  - An empty FIFO in WRITE or DROP just waits; no timeout.
  - desc_maxlen=0: the first word overruns, and the whole frame is dropped with len=0.
  - The length comparison uses LEN_WIDTH+1 bits so the sum cannot wrap.
  - The address wraps modulo 2^ADDR_WIDTH without a flag.
  - desc_valid outside IDLE is ignored.
  - No new descriptor is accepted until the cycle after DONE.

Optional Feature:
- Macro: ETH_RXDMA_FRAME_CNT_EN.
- Defined:
  - Adds outputs cnt_frames[15:0] and cnt_errors[15:0].
  - Both reset to 0.
  - cnt_frames increments on every DONE.
  - cnt_errors increments on DONE when err|ovr.
  - Both wrap from 0xFFFF to 0.
- Undefined: no ports and no logic.

Decomposition:
- Shared package eth_avalon_rxdma_pkg holds:
  - the state enum (IDLE/WRITE/DROP/DONE);
  - the FIFO field positions: DATA_MSB=31, CNT_LSB=32, EOF_BIT=34, ERR_BIT=35;
  - the byte-enable lookup function.
- One natural sub-module, eth_rxdma_len_chk: combinational word_bytes/byteenable decode plus the overrun compare.

Test Plan:
- Frame of 3 words, last word cnt=1, desc_addr=0x1000, maxlen=1518, no waitrequest → writes to 0x1000/0x1004/0x1008; last byteenable=0011; stat_len=10; err=0; ovr=0.
- Same frame with av_waitrequest held for 3 cycles on word 2 → address, data and byteenable stable throughout the stall; no pop until waitrequest drops; identical status.
- maxlen=6 with a 3-word frame → one write only; DROP pops words 2 and 3; stat_len=4; stat_overrun=1.
- EOF word carries bit35=1 → stat_err=1; the write still completes; with ETH_RXDMA_FRAME_CNT_EN, cnt_errors=1 and cnt_frames=1.
- FIFO empty for 10 cycles mid-frame → av_write=0 during the gap; resumes at the correct address.
- reset_n asserted mid-frame in WRITE → all outputs 0 immediately; after release desc_ready=1 and the next frame starts clean with len=0.
